// File: rtl/lsu_rmw_ctrl.sv
// Load/store unit between the CPU execute stage and the Bridge data bus.
// Registered req/ack bus handshake; sub-word stores are done as read-modify-write.
module lsu_rmw_ctrl #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              cpu_clk,
  input  logic              cpu_rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ack
);

  localparam int unsigned NB        = DATA_W / 8;
  localparam int unsigned LW        = $clog2(NB);
  localparam logic [1:0]  FULL_SIZE = 2'(LW);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_we;
  logic              r_unsigned;
  logic              r_err;
  logic [1:0]        r_size;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;

  logic              w_accept;
  logic              w_req_err;
  logic [2:0]        w_align_mask;
  logic [LW-1:0]     w_lane;
  int unsigned       w_lo;
  int unsigned       w_nbits;
  logic [DATA_W-1:0] w_shr;
  logic [DATA_W-1:0] w_shl;
  logic [DATA_W-1:0] w_ext;
  logic [DATA_W-1:0] w_merge;
  logic              w_sbit;
  logic              w_fill;

  always_comb begin
    w_accept = req_valid && (r_state == IDLE);
    case (req_size)
      2'd0:    w_align_mask = 3'b000;
      2'd1:    w_align_mask = 3'b001;
      2'd2:    w_align_mask = 3'b011;
      default: w_align_mask = 3'b111;
    endcase
    w_req_err = (req_size > FULL_SIZE) || ((req_addr[2:0] & w_align_mask) != 3'b000);
  end

  // Lane extraction for loads and byte-lane merge for sub-word stores,
  // both working on the bus word as it arrives in the read ack cycle.
  always_comb begin
    w_lane  = r_addr[LW-1:0];
    w_lo    = 32'({w_lane, 3'b000});
    w_nbits = 32'd8 << r_size;
    w_shr   = bus_rdata >> w_lo;
    w_shl   = r_wdata << w_lo;
    case (r_size)
      2'd0:    w_sbit = w_shr[7];
      2'd1:    w_sbit = w_shr[15];
      2'd2:    w_sbit = w_shr[31];
      default: w_sbit = w_shr[DATA_W-1];
    endcase
    w_fill  = !r_unsigned && w_sbit;
    w_ext   = '0;
    w_merge = '0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      w_ext[i]   = (i < w_nbits) ? w_shr[i] : w_fill;
      w_merge[i] = ((i >= w_lo) && (i < w_lo + w_nbits)) ? w_shl[i] : bus_rdata[i];
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          if (w_req_err)                             w_state_nxt = RESP;
          else if (req_we && (req_size == FULL_SIZE)) w_state_nxt = WR;
          else                                       w_state_nxt = RD;
        end
      end
      RD:      if (bus_ack) w_state_nxt = r_we ? WR : RESP;
      WR:      if (bus_ack) w_state_nxt = RESP;
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      r_we       <= 1'b0;
      r_unsigned <= 1'b0;
      r_err      <= 1'b0;
      r_size     <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
    end else if (w_accept) begin
      r_we       <= req_we;
      r_unsigned <= req_unsigned;
      r_err      <= w_req_err;
      r_size     <= req_size;
      r_addr     <= req_addr;
      r_wdata    <= req_wdata;
      r_rdata    <= '0;
    end else if ((r_state == RD) && bus_ack) begin
      if (r_we) r_wdata <= w_merge;
      else      r_rdata <= w_ext;
    end
  end

  // All outputs decode flops only, so bus signals stay stable until ack.
  always_comb begin
    req_ready  = (r_state == IDLE);
    bus_req    = (r_state == RD) || (r_state == WR);
    bus_we     = (r_state == WR);
    bus_addr   = {r_addr[ADDR_W-1:LW], {LW{1'b0}}};
    bus_wdata  = (r_state == WR) ? r_wdata : '0;
    resp_valid = (r_state == RESP);
    resp_err   = (r_state == RESP) && r_err;
    resp_rdata = (r_state == RESP) ? r_rdata : '0;
  end

endmodule
